// File: rtl/sar_search_pkg.sv
// Shared types for the successive-approximation search controller:
// state encoding and the comparator flag sanity check.
package sar_search_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_TRY    = 2'd1;
  localparam logic [1:0] ST_VERIFY = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;

  typedef enum logic [1:0] {
    IDLE   = ST_IDLE,
    TRY    = ST_TRY,
    VERIFY = ST_VERIFY,
    DONE   = ST_DONE
  } state_t;

  // flags are ordered {eq, less, greater}
  function automatic logic flags_one_hot(input logic [2:0] flags);
    return (flags == 3'b001) || (flags == 3'b010) || (flags == 3'b100);
  endfunction

endpackage

// File: rtl/sar_wait_cnt.sv
// Down-counter that holds each trial for CMP_LAT+1 cycles; zero marks the
// cycle on which the comparator flags are valid and get sampled.
module sar_wait_cnt #(
  parameter int CMP_LAT = 0
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  output logic zero
);

  localparam int CW = (CMP_LAT > 0) ? $clog2(CMP_LAT + 1) : 1;

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst)
      cnt <= '0;
    else if (load)
      cnt <= CW'(CMP_LAT);
    else if (cnt != '0)
      cnt <= cnt - CW'(1);
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/sar_search.sv
// Successive-approximation controller: drives the comparator's trial operand
// MSB first and settles on the target, with a final VERIFY sample.
module sar_search
  import sar_search_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int CMP_LAT = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic [WIDTH-1:0] trial,
  input  logic             cmp_eq,
  input  logic             cmp_less,
  input  logic             cmp_greater,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             found,
  output logic             error
);

  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_t           state, state_n;
  logic [IW-1:0]    idx, idx_n;
  logic [WIDTH-1:0] trial_n, result_n;
  logic             found_n, error_n;
  logic             load, wait_zero, sample;
  logic [WIDTH-1:0] cur_bit, kept;

  sar_wait_cnt #(.CMP_LAT(CMP_LAT)) u_wait (
    .clk  (clk),
    .rst  (rst),
    .load (load),
    .zero (wait_zero)
  );

  assign sample  = ((state == TRY) || (state == VERIFY)) && wait_zero;
  assign cur_bit = WIDTH'(1) << idx;
  // trial above target means the bit under test overshoots and is dropped
  assign kept    = cmp_greater ? (trial & ~cur_bit) : trial;

  always_comb begin
    state_n  = state;
    idx_n    = idx;
    trial_n  = trial;
    result_n = result;
    found_n  = found;
    error_n  = error;
    load     = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          trial_n  = WIDTH'(1) << (WIDTH - 1);
          idx_n    = IW'(WIDTH - 1);
          result_n = '0;
          found_n  = 1'b0;
          error_n  = 1'b0;
          load     = 1'b1;
          state_n  = TRY;
        end
      end
      TRY, VERIFY: begin
        if (sample) begin
          load = 1'b1;
          if (!flags_one_hot({cmp_eq, cmp_less, cmp_greater})) begin
            error_n  = 1'b1;
            result_n = trial;
            found_n  = 1'b0;
            state_n  = DONE;
          end else if (state == VERIFY) begin
            result_n = trial;
            found_n  = cmp_eq;
            state_n  = DONE;
          end else if (cmp_eq) begin
            result_n = trial;
            found_n  = 1'b1;
            state_n  = DONE;
          end else if (idx != '0) begin
            trial_n = kept | (cur_bit >> 1);
            idx_n   = idx - IW'(1);
          end else begin
            trial_n = kept;
            state_n = VERIFY;
          end
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      idx    <= '0;
      trial  <= '0;
      result <= '0;
      found  <= 1'b0;
      error  <= 1'b0;
    end else begin
      state  <= state_n;
      idx    <= idx_n;
      trial  <= trial_n;
      result <= result_n;
      found  <= found_n;
      error  <= error_n;
    end
  end

  assign busy = (state == TRY) || (state == VERIFY);
  assign done = (state == DONE);

endmodule

// File: tb/tb_sar_search.sv
// Bench for sar_search: a combinational-comparator instance (CMP_LAT=0) and a
// registered-comparator instance (CMP_LAT=2), each modelled against a target.
module tb_sar_search;

  localparam int W = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic start0, start2;
  logic [W-1:0] target0, target2;
  bit force_bad;

  logic [W-1:0] trial0, result0, trial2, result2;
  logic busy0, done0, found0, error0, eq0, less0, gt0;
  logic busy2, done2, found2, error2, eq2, less2, gt2;
  logic [W-1:0] p1, p2;

  sar_search #(.WIDTH(W), .CMP_LAT(0)) dut0 (
    .clk(clk), .rst(rst), .start(start0), .trial(trial0),
    .cmp_eq(eq0), .cmp_less(less0), .cmp_greater(gt0),
    .busy(busy0), .done(done0), .result(result0), .found(found0), .error(error0)
  );

  sar_search #(.WIDTH(W), .CMP_LAT(2)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .trial(trial2),
    .cmp_eq(eq2), .cmp_less(less2), .cmp_greater(gt2),
    .busy(busy2), .done(done2), .result(result2), .found(found2), .error(error2)
  );

  // comparator models
  assign eq0   = force_bad ? 1'b0 : (trial0 == target0);
  assign less0 = force_bad ? 1'b0 : (trial0 <  target0);
  assign gt0   = force_bad ? 1'b0 : (trial0 >  target0);

  always @(posedge clk) begin
    p1 <= trial2;
    p2 <= p1;
  end
  assign eq2   = (p2 == target2);
  assign less2 = (p2 <  target2);
  assign gt2   = (p2 >  target2);

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [5:0] exp_q[$];   // {error, found, result}

  // sample points the search needs: exits when it reaches target's lowest set bit
  function automatic int exp_samples(input logic [W-1:0] t);
    for (int b = 0; b < W; b++)
      if (t[b]) return W - b;
    return W + 1;
  endfunction

  task automatic wait_done0(input int max, output int n);
    n = 0;
    repeat (max) begin
      @(negedge clk);
      n++;
      if (done0 === 1'b1) return;
    end
    n = -1;
  endtask

  task automatic pop_check0(input string name);
    logic [5:0] exp;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s scoreboard empty got %h", name, {error0, found0, result0});
    end else begin
      exp = exp_q.pop_front();
      if ({error0, found0, result0} !== exp) begin
        errors++;
        $display("FAIL %s got err/found/result %h want %h", name, {error0, found0, result0}, exp);
      end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1; start0 = 1'b0; start2 = 1'b0; force_bad = 1'b0;
    target0 = '0; target2 = '0;
    repeat (3) @(negedge clk);
    checks++;
    if ({trial0, busy0, done0, result0, found0, error0} !== '0) begin
      errors++;
      $display("FAIL reset0 got %h want 0", {trial0, busy0, done0, result0, found0, error0});
    end
    checks++;
    if ({trial2, busy2, done2, result2, found2, error2} !== '0) begin
      errors++;
      $display("FAIL reset2 got %h want 0", {trial2, busy2, done2, result2, found2, error2});
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({busy0, done0, busy2, done2} !== 4'b0) begin
      errors++;
      $display("FAIL idle_after_reset got %b want 0000", {busy0, done0, busy2, done2});
    end
  endtask

  task automatic test_search_9();
    logic [W-1:0] seq [4];
    seq = '{4'd8, 4'd12, 4'd10, 4'd9};
    target0 = 4'd9;
    exp_q.push_back({1'b0, 1'b1, 4'd9});
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (trial0 !== seq[i] || busy0 !== 1'b1 || done0 !== 1'b0) begin
        errors++;
        $display("FAIL t9_trial%0d got trial=%0d busy=%b done=%b want %0d 1 0", i, trial0, busy0, done0, seq[i]);
      end
      @(negedge clk);
    end
    checks++;
    if (done0 !== 1'b1 || busy0 !== 1'b0) begin
      errors++;
      $display("FAIL t9_done got done=%b busy=%b want 1 0", done0, busy0);
    end
    pop_check0("t9_result");
    @(negedge clk);
    checks++;
    if (done0 !== 1'b0 || trial0 !== 4'd9 || result0 !== 4'd9) begin
      errors++;
      $display("FAIL t9_hold got done=%b trial=%0d result=%0d want 0 9 9", done0, trial0, result0);
    end
  endtask

  task automatic test_target_zero();
    logic [W-1:0] seq [5];
    seq = '{4'd8, 4'd4, 4'd2, 4'd1, 4'd0};
    target0 = 4'd0;
    exp_q.push_back({1'b0, 1'b1, 4'd0});
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (trial0 !== seq[i] || busy0 !== 1'b1 || done0 !== 1'b0) begin
        errors++;
        $display("FAIL t0_trial%0d got trial=%0d busy=%b done=%b want %0d 1 0", i, trial0, busy0, done0, seq[i]);
      end
      @(negedge clk);
    end
    checks++;
    if (done0 !== 1'b1) begin
      errors++;
      $display("FAIL t0_done got %b want 1", done0);
    end
    pop_check0("t0_result");
    @(negedge clk);
  endtask

  task automatic test_latency();
    logic [W-1:0] seq [3];
    logic [5:0] exp;
    seq = '{4'd8, 4'd4, 4'd6};
    target2 = 4'd6;
    exp_q.push_back({1'b0, 1'b1, 4'd6});
    start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    for (int i = 0; i < 9; i++) begin
      checks++;
      if (trial2 !== seq[i/3] || busy2 !== 1'b1 || done2 !== 1'b0) begin
        errors++;
        $display("FAIL lat2_cycle%0d got trial=%0d busy=%b done=%b want %0d 1 0", i, trial2, busy2, done2, seq[i/3]);
      end
      @(negedge clk);
    end
    checks++;
    exp = exp_q.pop_front();
    if (done2 !== 1'b1 || {error2, found2, result2} !== exp) begin
      errors++;
      $display("FAIL lat2_done got done=%b err/found/result=%h want 1 %h", done2, {error2, found2, result2}, exp);
    end
    @(negedge clk);
  endtask

  task automatic test_bad_flags();
    force_bad = 1'b1;
    target0 = 4'd5;
    exp_q.push_back({1'b1, 1'b0, 4'd8});
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    checks++;
    if (trial0 !== 4'd8 || busy0 !== 1'b1) begin
      errors++;
      $display("FAIL bad_first got trial=%0d busy=%b want 8 1", trial0, busy0);
    end
    @(negedge clk);
    checks++;
    if (done0 !== 1'b1) begin
      errors++;
      $display("FAIL bad_done got %b want 1", done0);
    end
    pop_check0("bad_flags");
    force_bad = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_abort();
    int n;
    target0 = 4'd15;
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    checks++;
    if (trial0 !== 4'd8) begin
      errors++;
      $display("FAIL abort_t1 got %0d want 8", trial0);
    end
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    checks++;
    if (trial0 !== 4'd12 || busy0 !== 1'b1) begin
      errors++;
      $display("FAIL abort_ignore_start got trial=%0d busy=%b want 12 1", trial0, busy0);
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({trial0, busy0, done0, result0, found0, error0} !== '0) begin
      errors++;
      $display("FAIL abort_rst got %h want 0", {trial0, busy0, done0, result0, found0, error0});
    end
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (done0 !== 1'b0 || busy0 !== 1'b0) begin
        errors++;
        $display("FAIL abort_quiet%0d got done=%b busy=%b want 0 0", i, done0, busy0);
      end
    end
    exp_q.push_back({1'b0, 1'b1, 4'd15});
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    wait_done0(20, n);
    checks++;
    if (n < 0 || n + 1 != exp_samples(4'd15) + 1) begin
      errors++;
      $display("FAIL abort_rerun_latency got %0d want %0d", n + 1, exp_samples(4'd15) + 1);
    end
    pop_check0("abort_rerun");
    @(negedge clk);
  endtask

  task automatic test_random();
    int n;
    for (int k = 0; k < 8; k++) begin
      target0 = W'($urandom_range(0, 15));
      exp_q.push_back({1'b0, 1'b1, target0});
      start0 = 1'b1;
      @(negedge clk);
      start0 = 1'b0;
      wait_done0(20, n);
      checks++;
      if (n < 0 || n + 1 != exp_samples(target0) + 1) begin
        errors++;
        $display("FAIL rand%0d_latency target=%0d got %0d want %0d", k, target0, n + 1, exp_samples(target0) + 1);
      end
      pop_check0("rand_result");
      @(negedge clk);
    end
  endtask

  task automatic test_back_to_back();
    int n;
    target0 = 4'd3;
    exp_q.push_back({1'b0, 1'b1, 4'd3});
    exp_q.push_back({1'b0, 1'b1, 4'd12});
    start0 = 1'b1;
    wait_done0(20, n);
    checks++;
    if (n != exp_samples(4'd3) + 1) begin
      errors++;
      $display("FAIL b2b_first_latency got %0d want %0d", n, exp_samples(4'd3) + 1);
    end
    pop_check0("b2b_first");
    target0 = 4'd12;
    @(negedge clk);
    checks++;
    if (busy0 !== 1'b0 || done0 !== 1'b0 || trial0 !== 4'd3) begin
      errors++;
      $display("FAIL b2b_idle got busy=%b done=%b trial=%0d want 0 0 3", busy0, done0, trial0);
    end
    @(negedge clk);
    checks++;
    if (busy0 !== 1'b1 || trial0 !== 4'd8 || result0 !== 4'd0) begin
      errors++;
      $display("FAIL b2b_restart got busy=%b trial=%0d result=%0d want 1 8 0", busy0, trial0, result0);
    end
    wait_done0(20, n);
    checks++;
    if (n != exp_samples(4'd12)) begin
      errors++;
      $display("FAIL b2b_second_latency got %0d want %0d", n, exp_samples(4'd12));
    end
    pop_check0("b2b_second");
    start0 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (busy0 !== 1'b0 || done0 !== 1'b0 || result0 !== 4'd12) begin
      errors++;
      $display("FAIL b2b_settle got busy=%b done=%b result=%0d want 0 0 12", busy0, done0, result0);
    end
  endtask

  // ---------------- sequence / report ----------------
  initial begin
    test_reset();
    test_search_9();
    test_target_zero();
    test_latency();
    test_bad_flags();
    test_abort();
    test_random();
    test_back_to_back();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_leftover got %0d want 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/sar_search.md
Name: sar_search

Overview:
- Successive-approximation controller that drives the trial operand of an external magnitude comparator; the comparator's second operand is an unknown target.
- It reads back the comparator's one-hot eq/less/greater result and binary-searches for the target value, MSB first.
- It is the initiator side of the comparator interface and supplies operands to the existing combinational comparator or to any registered one.

Parameters:
- WIDTH, 4: bit width of trial and result.
- CMP_LAT, 0: extra cycles the comparator needs before its flags are valid. 0 means purely combinational.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request a search; sampled only in IDLE.
- trial  out  WIDTH  candidate driven to the comparator's "a" operand (registered).
- cmp_eq  in  1  comparator result: trial == target.
- cmp_less  in  1  comparator result: trial < target.
- cmp_greater  in  1  comparator result: trial > target.
- busy  out  1  high while a search is in progress.
- done  out  1  one-cycle pulse when the search ends.
- result  out  WIDTH  final value; held until the next accepted start.
- found  out  1  target confirmed equal to result.
- error  out  1  comparator flags were not one-hot at a sample point.

Behaviour:
- Reset: all outputs 0, state IDLE, wait counter 0. Reset mid-search aborts on the next edge, with no done pulse.
- States and transitions:
  - IDLE: if start, trial <= 1<<(WIDTH-1), bit index <= WIDTH-1, clear found/error/result, go to TRY.
  - TRY: hold trial for CMP_LAT+1 cycles, counting with the wait counter. On the final cycle, sample the flags:
    - eq: result <= trial, found <= 1, go to DONE (early exit).
    - less: keep the current bit.
    - greater: clear the current bit.
    - If bit index > 0: trial <= kept value | (1 << (index-1)), index decrements, stay in TRY.
    - If index == 0: trial <= kept value, go to VERIFY.
  - VERIFY: hold trial for CMP_LAT+1 cycles, then sample. result <= trial, found <= cmp_eq, go to DONE.
  - DONE: done = 1 for exactly one cycle, busy = 0, go to IDLE.
- busy = 1 in TRY and VERIFY only.
- Flag check: at any sample point, if {eq,less,greater} is not exactly one-hot, error <= 1, result <= trial, found <= 0, go to DONE.
- start while not in IDLE is ignored; there is no queuing.
- start in the DONE cycle is ignored. start in the first IDLE cycle after DONE is accepted.
- Maximum latency: WIDTH+1 sample points at (CMP_LAT+1) cycles each, then 1 DONE cycle.
- trial changes only on sample edges. It holds its last value in DONE/IDLE until the next start.
- All arithmetic is WIDTH bits unsigned with no wrap; index is clog2(WIDTH) bits wide, minimum 1.

Decomposition:
- Shared package: state encoding localparams (IDLE, TRY, VERIFY, DONE), 2-bit state type, and a one-hot check function for the 3 flags.
- The wait counter is a natural sub-module: sar_wait_cnt, a CMP_LAT-bounded down-counter with load and a zero flag. Everything else stays inline.

Test Plan (WIDTH=4; the bench models the comparator against a target unless noted):
- CMP_LAT=0, target 9, start pulse: trial sequence 8, 12, 10, 9 on consecutive cycles. Next cycle: done=1, result=9, found=1, error=0.
- CMP_LAT=0, target 0: trials 8, 4, 2, 1 (all greater), then VERIFY trial 0 (eq). Then done with result=0, found=1; 5 sample cycles total.
- CMP_LAT=2, target 6: each trial is held 3 cycles. Sequence 8, 4, 6 with eq at 6. Done 9 cycles after start, result=6.
- Bench forces flags 000 at the first sample: next cycle done=1, error=1, found=0, result=8.
- Target 15 search with start re-pulsed mid-search and then rst asserted on the 2nd trial: the start is ignored. After rst, all outputs are 0 and no done pulse occurs. A new start then searches normally.
- Back-to-back: start held high continuously with targets 3 then 12. The second search begins in the first IDLE cycle after DONE; results are 3 then 12.
